// File: rtl/regfile_dump.sv
// Integer register file with two combinational read ports, one write port and
// a ready/valid dump engine that streams every register out in index order.
module regfile_dump #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            dump_start,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_last,
    output logic            dump_busy,
    output logic            dump_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_en;

    state_e          state_q;
    logic [AW-1:0]   idx_q;
    logic [XLEN-1:0] data_q;
    logic            valid_q;
    logic            last_q;
    logic            busy_q;
    logic            done_q;

    logic [AW-1:0]   cap_idx_d;
    logic [XLEN-1:0] cap_data_d;

    // Forwarded read shared by both read ports and the dump capture path.
    function automatic logic [XLEN-1:0] fwd(
        input logic [AW-1:0]   a,
        input logic [XLEN-1:0] stored,
        input logic            w,
        input logic [AW-1:0]   wa,
        input logic [XLEN-1:0] wd
    );
        if (ZERO_REG && a == '0)
            return '0;
        else if (BYPASS && w && wa == a)
            return wd;
        else
            return stored;
    endfunction

    assign wr_en = we && !(ZERO_REG && rd_addr == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = fwd(rs1_addr, regs_q[rs1_addr], wr_en, rd_addr, rd_data);
    assign rs2_data = fwd(rs2_addr, regs_q[rs2_addr], wr_en, rd_addr, rd_data);

    always_comb begin
        cap_idx_d  = (state_q == IDLE) ? '0 : idx_q + 1'b1;
        cap_data_d = fwd(cap_idx_d, regs_q[cap_idx_d], wr_en, rd_addr, rd_data);
    end

    // Status flags are registered alongside the state so they switch cleanly on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dump_start) begin
                        state_q <= STREAM;
                        idx_q   <= cap_idx_d;
                        data_q  <= cap_data_d;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (dump_ready) begin
                        if (last_q) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= cap_idx_d;
                            data_q <= cap_data_d;
                            last_q <= (cap_idx_d == AW'(NREG - 1));
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_valid = valid_q;
    assign dump_idx   = idx_q;
    assign dump_data  = data_q;
    assign dump_last  = last_q;
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: default, no-bypass and small (16x8, writable x0) instances.
module tb_regfile_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data, rd_data;
    logic        we, dump_start, dump_ready;
    logic        dump_valid, dump_last, dump_busy, dump_done;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        nb_dump_valid, nb_dump_last, nb_dump_busy, nb_dump_done;
    logic [4:0]  nb_dump_idx;
    logic [31:0] nb_dump_data;

    logic [2:0]  s_rs1_addr, s_rs2_addr, s_rd_addr, s_dump_idx;
    logic [15:0] s_rs1_data, s_rs2_data, s_rd_data, s_dump_data;
    logic        s_we, s_dump_start, s_dump_ready;
    logic        s_dump_valid, s_dump_last, s_dump_busy, s_dump_done;

    regfile_dump dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    regfile_dump #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .dump_start(dump_start), .dump_valid(nb_dump_valid), .dump_ready(dump_ready),
        .dump_idx(nb_dump_idx), .dump_data(nb_dump_data), .dump_last(nb_dump_last),
        .dump_busy(nb_dump_busy), .dump_done(nb_dump_done)
    );

    regfile_dump #(.XLEN(16), .NREG(8), .ZERO_REG(1'b0)) dut_s (
        .clk(clk), .reset(reset),
        .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr),
        .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
        .we(s_we), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .dump_start(s_dump_start), .dump_valid(s_dump_valid), .dump_ready(s_dump_ready),
        .dump_idx(s_dump_idx), .dump_data(s_dump_data), .dump_last(s_dump_last),
        .dump_busy(s_dump_busy), .dump_done(s_dump_done)
    );

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [2:0]  idx;
        logic [15:0] data;
        logic        last;
    } s_beat_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1, a2;
        logic [31:0] e1, e2;   // BYPASS=1
        logic [31:0] n1, n2;   // BYPASS=0
    } vec_t;

    beat_t       sbq[$];
    s_beat_t     s_sbq[$];
    logic [31:0] mdl [32];
    logic [15:0] s_mdl [8];
    vec_t        vecs [8];
    int          npass = 0;
    int          ntotal = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic dump_main(input int hold_at, input int hold_n, input logic [31:0] hold_wd);
        beat_t b;
        int    cyc;
        bit    held;
        for (int i = 0; i < 32; i++) begin
            b.idx  = 5'(i);
            b.data = mdl[i];
            b.last = (i == 31);
            sbq.push_back(b);
        end
        @(negedge clk); dump_start = 1'b1; dump_ready = 1'b1;
        @(negedge clk); dump_start = 1'b0;
        cyc  = 0;
        held = 1'b0;
        while (sbq.size() > 0 && cyc < 100) begin
            #1;
            if (!held && hold_at >= 0 && dump_valid && int'(dump_idx) == hold_at) begin
                held = 1'b1;
                dump_ready = 1'b0;
                we = 1'b1; rd_addr = 5'(hold_at); rd_data = hold_wd;
                mdl[hold_at] = hold_wd;
                for (int k = 0; k < hold_n; k++) begin
                    chk("hold_valid", 64'(dump_valid), 64'(1));
                    chk("hold_idx", 64'(dump_idx), 64'(hold_at));
                    chk("hold_data", 64'(dump_data), 64'(sbq[0].data));
                    @(negedge clk); we = 1'b0; #1;
                end
                dump_ready = 1'b1;
            end
            if (dump_valid && dump_ready) begin
                b = sbq.pop_front();
                chk($sformatf("beat%0d", b.idx), 64'({dump_idx, dump_data, dump_last}),
                    64'({b.idx, b.data, b.last}));
            end else begin
                chk("beat_present", 64'(dump_valid), 64'(1));
            end
            cyc++;
            @(negedge clk);
        end
        chk("dump_cycles", 64'(cyc), 64'(32));
        chk("beats_left", 64'(sbq.size()), 64'(0));
        sbq.delete();
        #1;
        chk("done_pulse", 64'({dump_done, dump_busy, dump_valid}), 64'(3'b110));
        dump_start = 1'b1;
        @(negedge clk); #1;
        chk("back_idle", 64'({dump_done, dump_busy, dump_valid}), 64'(3'b000));
        dump_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rs1_addr = 5'd5; rs2_addr = 5'd0; rd_addr = '0; rd_data = '0; we = 1'b0;
        dump_start = 1'b0; dump_ready = 1'b0;
        s_rs1_addr = '0; s_rs2_addr = '0; s_rd_addr = '0; s_rd_data = '0; s_we = 1'b0;
        s_dump_start = 1'b0; s_dump_ready = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;

        vecs[0] = '{1'b1, 5'd5,  32'h1234,     5'd1,  5'd2,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFF,     5'd5,  5'd0,  32'h1234,     32'h0,        32'h1234,     32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'h1234,     32'h0,        32'h1234};
        vecs[3] = '{1'b1, 5'd7,  32'hAA,       5'd7,  5'd5,  32'hAA,       32'h1234,     32'h0,        32'h1234};
        vecs[4] = '{1'b1, 5'd7,  32'hBB,       5'd7,  5'd7,  32'hBB,       32'hBB,       32'hAA,       32'hAA};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 32'hBB,       32'h0,        32'hBB,       32'h0};
        vecs[6] = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd3,  5'd31, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};

        @(negedge clk); #1;
        chk("rst_status", 64'({dump_valid, dump_last, dump_done, dump_busy}), 64'(0));
        chk("rst_beat", 64'({dump_idx, dump_data}), 64'(0));
        chk("rst_read", 64'({rs1_data, rs2_data}), 64'(0));
        chk("rst_small", 64'({s_dump_valid, s_dump_busy, s_rs1_data}), 64'(0));
        reset = 1'b0;

        foreach (vecs[v]) begin
            @(negedge clk);
            we = vecs[v].we; rd_addr = vecs[v].wa; rd_data = vecs[v].wd;
            rs1_addr = vecs[v].a1; rs2_addr = vecs[v].a2;
            if (vecs[v].we && vecs[v].wa != 5'd0) mdl[vecs[v].wa] = vecs[v].wd;
            #1;
            chk($sformatf("v%0d_rs1", v), 64'(rs1_data), 64'(vecs[v].e1));
            chk($sformatf("v%0d_rs2", v), 64'(rs2_data), 64'(vecs[v].e2));
            chk($sformatf("v%0d_nb_rs1", v), 64'(nb_rs1_data), 64'(vecs[v].n1));
            chk($sformatf("v%0d_nb_rs2", v), 64'(nb_rs2_data), 64'(vecs[v].n2));
        end

        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1; rd_addr = 5'(i); rd_data = 32'(3 * i);
            mdl[i] = 32'(3 * i);
        end
        @(negedge clk); we = 1'b0;

        dump_main(-1, 0, 32'h0);
        dump_main(10, 4, 32'h55);
        dump_main(-1, 0, 32'h0);

        // Reset in the middle of a dump
        @(negedge clk); dump_start = 1'b1; dump_ready = 1'b1;
        @(negedge clk); dump_start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (dump_valid && dump_idx == 5'd12) break;
            @(negedge clk);
        end
        chk("reach_idx12", 64'({dump_valid, dump_idx}), 64'({1'b1, 5'd12}));
        reset = 1'b1;
        rs1_addr = 5'd10; rs2_addr = 5'd31;
        #1;
        chk("mid_rst_status", 64'({dump_valid, dump_busy, dump_last, dump_done}), 64'(0));
        chk("mid_rst_beat", 64'({dump_idx, dump_data}), 64'(0));
        chk("mid_rst_regs", 64'({rs1_data, rs2_data}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("no_done_after_rst", 64'({dump_done, dump_busy}), 64'(0));
        end
        dump_main(-1, 0, 32'h0);

        // Small parameter set: x0 is an ordinary register
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_we = 1'b1; s_rd_addr = 3'(i); s_rd_data = 16'hA500 + 16'(i);
            s_mdl[i] = 16'hA500 + 16'(i);
        end
        @(negedge clk);
        s_we = 1'b0; s_rs1_addr = 3'd0; s_rs2_addr = 3'd7;
        #1;
        chk("s_x0", 64'(s_rs1_data), 64'(16'hA500));
        chk("s_x7", 64'(s_rs2_data), 64'(16'hA507));
        begin
            s_beat_t sb;
            int      cyc;
            for (int i = 0; i < 8; i++) begin
                sb.idx = 3'(i); sb.data = s_mdl[i]; sb.last = (i == 7);
                s_sbq.push_back(sb);
            end
            @(negedge clk); s_dump_start = 1'b1; s_dump_ready = 1'b1;
            @(negedge clk); s_dump_start = 1'b0;
            cyc = 0;
            while (s_sbq.size() > 0 && cyc < 40) begin
                #1;
                if (s_dump_valid) begin
                    sb = s_sbq.pop_front();
                    chk($sformatf("s_beat%0d", sb.idx), 64'({s_dump_idx, s_dump_data, s_dump_last}),
                        64'({sb.idx, sb.data, sb.last}));
                end else begin
                    chk("s_beat_present", 64'(s_dump_valid), 64'(1));
                end
                cyc++;
                @(negedge clk);
            end
            chk("s_dump_cycles", 64'(cyc), 64'(8));
            #1;
            chk("s_done_pulse", 64'({s_dump_done, s_dump_busy, s_dump_valid}), 64'(3'b110));
            @(negedge clk); #1;
            chk("s_back_idle", 64'({s_dump_done, s_dump_busy}), 64'(0));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
